// File: rtl/lfsr_ms_gen.sv
// Multi-step Fibonacci LFSR with XNOR feedback, seed load, wrap and lock-up flags.
// Optional: define LFSR_LOCKUP_RECOVER_EN to auto-recover from the all-ones state.
module lfsr_ms_gen #(
  parameter int unsigned N         = 6,
  parameter logic [N-1:0] TAPS     = 6'b110000,
  parameter int unsigned STEPS     = 3,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic [N-1:0] y,
  output logic         wrap,
  output logic         lockup
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  // Parameter sanity checks at elaboration
  if (N < 3 || N > 32) begin : g_bad_width
    $error("lfsr_ms_gen: N must be in 3..32");
  end
  if (STEPS < 1 || STEPS > N) begin : g_bad_steps
    $error("lfsr_ms_gen: STEPS must be in 1..N");
  end
  if (($countones(TAPS) % 2) != 0) begin : g_bad_taps
    $error("lfsr_ms_gen: TAPS popcount must be even");
  end
  if (RESET_VAL == ALL_ONES) begin : g_bad_reset
    $error("lfsr_ms_gen: RESET_VAL must not be all-ones");
  end

  // One XNOR-feedback shift: stage i takes stage i-1, stage 1 takes feedback
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] x);
    logic fb;
    fb = ~(^(x & TAPS));
    return {x[N-2:0], fb};
  endfunction

  logic [N-1:0] ref_val;
  logic [N-1:0] next_val;
  logic         next_ones;
  logic         next_wrap;

  // STEPS single shifts unrolled into one combinational update
  always_comb begin
    next_val = y;
    for (int unsigned i = 0; i < STEPS; i++) begin
      next_val = lfsr_step(next_val);
    end
    next_ones = (next_val == ALL_ONES);
    // The all-ones fixed point never reports a wrap
    next_wrap = (next_val == ref_val) && !next_ones;
  end

  // State, reference and flag registers; load > recovery > en > hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y       <= RESET_VAL;
      ref_val <= RESET_VAL;
      wrap    <= 1'b0;
      lockup  <= 1'b0;
    end else if (load) begin
      y       <= seed;
      ref_val <= seed;
      wrap    <= 1'b0;
      lockup  <= (seed == ALL_ONES);
`ifdef LFSR_LOCKUP_RECOVER_EN
    end else if (lockup && en) begin
      y       <= RESET_VAL;
      ref_val <= RESET_VAL;
      wrap    <= 1'b0;
      lockup  <= 1'b0;
`endif
    end else if (en) begin
      y      <= next_val;
      wrap   <= next_wrap;
      lockup <= next_ones;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_ms_gen.sv
// Self-checking bench for lfsr_ms_gen: STEPS=3 (default) and STEPS=1 instances vs. an arithmetic model.
module tb_lfsr_ms_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       load;
  logic [5:0] seed;

  logic [5:0] y3, y1;
  logic       wrap3, wrap1, lock3, lock1;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 = STEPS 3, index 1 = STEPS 1
  logic [5:0] m_y   [2];
  logic [5:0] m_ref [2];
  logic       m_wrap[2];
  logic       m_lock[2];
  int         m_steps[2] = '{3, 1};

  always #5 clk = ~clk;

  lfsr_ms_gen dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .y(y3), .wrap(wrap3), .lockup(lock3)
  );

  lfsr_ms_gen #(.STEPS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .y(y1), .wrap(wrap1), .lockup(lock1)
  );

  // Feedback = 1 when an even number of tapped stages (6 and 5) are ones
  function automatic logic [5:0] mstep(input logic [5:0] x);
    int fb;
    int v;
    fb = (($countones(x & 6'b110000) % 2) == 0) ? 1 : 0;
    v  = (int'(x) * 2 + fb) % 64;
    return 6'(v);
  endfunction

  function automatic logic [5:0] mmulti(input logic [5:0] x, input int k);
    logic [5:0] r;
    r = x;
    for (int i = 0; i < k; i++) r = mstep(r);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 6'h00; m_ref[k] = 6'h00; m_wrap[k] = 1'b0; m_lock[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [5:0] nx;
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        m_y[k] = seed; m_ref[k] = seed; m_wrap[k] = 1'b0; m_lock[k] = (seed == 6'h3F);
`ifdef LFSR_LOCKUP_RECOVER_EN
      end else if (m_lock[k] && en) begin
        m_y[k] = 6'h00; m_ref[k] = 6'h00; m_wrap[k] = 1'b0; m_lock[k] = 1'b0;
`endif
      end else if (en) begin
        nx = mmulti(m_y[k], m_steps[k]);
        m_wrap[k] = (nx == m_ref[k]) && (nx != 6'h3F);
        m_lock[k] = (nx == 6'h3F);
        m_y[k]    = nx;
      end else begin
        m_wrap[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".y3"},    32'(y3),    32'(m_y[0]));
    chk({tag, ".wrap3"}, 32'(wrap3), 32'(m_wrap[0]));
    chk({tag, ".lock3"}, 32'(lock3), 32'(m_lock[0]));
    chk({tag, ".y1"},    32'(y1),    32'(m_y[1]));
    chk({tag, ".wrap1"}, 32'(wrap1), 32'(m_wrap[1]));
    chk({tag, ".lock1"}, 32'(lock1), 32'(m_lock[1]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    bit seen3 [64];
    bit seen1 [64];
    int n3, n1;

    // Reset state
    reset_n = 1'b0; en = 1'b0; load = 1'b0; seed = 6'h00;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Free-run from reset: first values, wrap cadence, distinct states
    for (int i = 0; i < 64; i++) begin seen3[i] = 1'b0; seen1[i] = 1'b0; end
    n3 = 0; n1 = 0;
    en = 1'b1;
    for (int c = 1; c <= 63; c++) begin
      tick("run");
      if (c <= 21 && !seen3[y3]) begin seen3[y3] = 1'b1; n3++; end
      if (!seen1[y1]) begin seen1[y1] = 1'b1; n1++; end
      if (c == 1) begin chk("first_y3", 32'(y3), 32'h07); chk("first_y1", 32'(y1), 32'h01); end
      if (c == 2) begin chk("second_y3", 32'(y3), 32'h3E); chk("second_y1", 32'(y1), 32'h03); end
      if (c == 3) chk("third_y1", 32'(y1), 32'h07);
      chk("wrap3_cadence", 32'(wrap3), (c % 21 == 0) ? 32'd1 : 32'd0);
      chk("wrap1_cadence", 32'(wrap1), (c == 63) ? 32'd1 : 32'd0);
    end
    chk("distinct3", 32'(n3), 32'd21);
    chk("distinct1", 32'(n1), 32'd63);

    // Load beats en, then wrap back to the seed 21 clocks later
    load = 1'b1; seed = 6'h15;
    tick("load");
    chk("load_y3", 32'(y3), 32'h15);
    load = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      tick("after_load");
      if (c == 21) begin
        chk("seed_wrap3", 32'(wrap3), 32'd1);
        chk("seed_wrap_y3", 32'(y3), 32'h15);
      end
    end

    // All-ones lock-up
    en = 1'b0; load = 1'b1; seed = 6'h3F;
    tick("load_ones");
    chk("lockup_set", 32'(lock3), 32'd1);
    load = 1'b0; en = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick("locked");
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (c == 1) begin chk("recover_y", 32'(y3), 32'h00); chk("recover_lock", 32'(lock3), 32'd0); end
      if (c == 2) chk("recover_next", 32'(y3), 32'h07);
`else
      chk("stuck_y", 32'(y3), 32'h3F);
      chk("stuck_wrap", 32'(wrap3), 32'd0);
`endif
    end

    // Asynchronous reset mid-cycle with lockup set
    load = 1'b1; seed = 6'h3F;
    tick("preload");
    load = 1'b0; en = 1'b1;
    tick("pre_reset");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_reset");
    chk("async_y3", 32'(y3), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    tick("resume");
    chk("resume_y3", 32'(y3), 32'h07);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      en   = (($urandom % 4) != 0);
      load = (($urandom % 16) == 0);
      seed = (($urandom % 4) == 0) ? 6'h3F : 6'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
